// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle for alu_cmd_sequencer.
//  cmd_*  : command port (valid/ready) from the requester into the sequencer
//  rsp_*  : response port (valid/ready) from the sequencer back to the requester
//  master : requester side, slave : sequencer side
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic [3:0] cmd_imm;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_rd;
  logic [3:0] rsp_result;
  logic [4:0] rsp_flags;

  modport master (
    output cmd_valid, cmd_opcode, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rd, rsp_result, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rd, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator for alu_4bit: queues commands, reads operands from a 4x4-bit
// register file, drives the ALU, writes results back and returns responses.
// Ports:
//  clk, rst_n        clock, synchronous active-low reset
//  bus (slave)       command in (valid/ready) and response out (valid/ready)
//  alu_a/b/opcode    registered operands and opcode to alu_4bit
//  alu_result/flags  combinational alu_4bit outputs
//  op_count          completed commands, wraps 255->0
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_opcode,
  input  logic [3:0]           alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_neg,
  input  logic                 alu_carry,
  input  logic                 alu_parity,
  output logic [7:0]           op_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [3:0]  OP_LOADI = 4'b1100;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] imm;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t             state, state_d;
  cmd_t               mem [DEPTH];
  cmd_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_d;
  logic [3:0]         regs [4];
  logic [1:0]         cur_rd;
  logic [3:0]         cur_imm;
  logic               cur_loadi;
  logic [3:0]         wdata;
  logic               push, pop, issue, rsp_done;

  assign push  = bus.cmd_valid && bus.cmd_ready;
  assign head  = mem[rd_ptr];
  assign wdata = cur_loadi ? cur_imm : alu_result;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    issue    = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CNT_W'(1);
    else if (!push && pop) count_d = count - CNT_W'(1);
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{opcode: bus.cmd_opcode, rd: bus.cmd_rd, ra: bus.cmd_ra,
                               rb: bus.cmd_rb, imm: bus.cmd_imm};
  end

  // Queue control, operand fetch, writeback and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.cmd_ready  <= 1'b1;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      cur_rd         <= '0;
      cur_imm        <= '0;
      cur_loadi      <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rd     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      op_count       <= '0;
    end else begin
      count <= count_d;
      // Registered ready: refuses a push when full even if a pop happens
      bus.cmd_ready <= (count_d != CNT_W'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        alu_a      <= regs[head.ra];
        alu_b      <= regs[head.rb];
        alu_opcode <= head.opcode;
        cur_rd     <= head.rd;
        cur_imm    <= head.imm;
        cur_loadi  <= (head.opcode == OP_LOADI);
      end
      if (issue) begin
        regs[cur_rd]   <= wdata;
        bus.rsp_result <= wdata;
        bus.rsp_rd     <= cur_rd;
        bus.rsp_valid  <= 1'b1;
        op_count       <= op_count + 8'(1);
        // LOADI bypasses the ALU, so the previous flags are kept
        if (!cur_loadi)
          bus.rsp_flags <= {alu_parity, alu_carry, alu_neg, alu_overflow, alu_zero};
      end
      if (rsp_done) bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural alu_4bit.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LOADI = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_opcode, alu_result;
  logic       alu_zero, alu_overflow, alu_neg, alu_carry, alu_parity;
  logic [7:0] op_count;

  alu_cmd_sequencer_if ifc ();

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_parity(alu_parity),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural alu_4bit: ADD, SUB, AND, OR; anything else yields 0
  logic [4:0] ext;
  always_comb begin
    ext          = 5'd0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        ext = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[3] == alu_b[3]) && (ext[3] != alu_a[3]);
      end
      4'b0001: begin
        ext = {1'b0, alu_a} - {1'b0, alu_b};
        alu_overflow = (alu_a[3] != alu_b[3]) && (ext[3] != alu_a[3]);
      end
      4'b0010: ext = {1'b0, alu_a & alu_b};
      4'b0011: ext = {1'b0, alu_a | alu_b};
      default: ext = 5'd0;
    endcase
    alu_result = ext[3:0];
    alu_carry  = ext[4];
    alu_zero   = (ext[3:0] == 4'd0);
    alu_neg    = ext[3];
    alu_parity = ^ext[3:0];
  end

  typedef struct {
    logic [1:0] rd;
    logic [3:0] result;
    logic [4:0] flags;
    int         cyc;
  } rsp_t;

  rsp_t rq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc++;

  // Capture each response handshake that will complete at the next edge
  always @(negedge clk) begin
    if (rst_n && ifc.rsp_valid && ifc.rsp_ready)
      rq.push_back('{rd: ifc.rsp_rd, result: ifc.rsp_result, flags: ifc.rsp_flags, cyc: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [3:0] imm);
    logic acc;
    acc = 1'b0;
    ifc.cmd_opcode = op;
    ifc.cmd_rd     = rd;
    ifc.cmd_ra     = ra;
    ifc.cmd_rb     = rb;
    ifc.cmd_imm    = imm;
    ifc.cmd_valid  = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = ifc.cmd_ready;
      tick();
    end
    ifc.cmd_valid = 1'b0;
    if (!acc) check("push_accept", 32'(acc), 32'd1);
  endtask

  // Wait for n captured responses, then one more edge so the last handshake completes
  task automatic wait_rsp(input int n);
    for (int t = 0; t < 100 && rq.size() < n; t++) tick();
    check("rsp_count", 32'(rq.size()), 32'(n));
    tick();
  endtask

  task automatic expect_rsp(input string tag, input logic [1:0] rd, input logic [3:0] res);
    rsp_t r;
    if (rq.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
      return;
    end
    r = rq.pop_front();
    check({tag, "_rd"}, 32'(r.rd), 32'(rd));
    check({tag, "_result"}, 32'(r.result), 32'(res));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rsp_t r;
    int   n_acc;
    logic rdy6;
    int   c0, c1, c2;

    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_opcode = '0; ifc.cmd_rd = '0; ifc.cmd_ra = '0; ifc.cmd_rb = '0; ifc.cmd_imm = '0;
    ifc.rsp_ready = 1'b1;
    tick(); tick();
    check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_rsp_result", 32'(ifc.rsp_result), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: LOADI r0=4, LOADI r1=8, ADD r2=r0+r1
    push(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'd4);
    push(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'd8);
    push(OP_ADD,   2'd2, 2'd0, 2'd1, 4'd0);
    wait_rsp(3);
    if (rq.size() > 0) check("t1_loadi_flags", 32'(rq[0].flags), 32'd0);
    expect_rsp("t1_r0", 2'd0, 4'd4);
    expect_rsp("t1_r1", 2'd1, 4'd8);
    if (rq.size() > 0) check("t1_add_flags", 32'(rq[0].flags), 32'b00100);
    expect_rsp("t1_add", 2'd2, 4'd12);
    check("t1_op_count", 32'(op_count), 32'd3);

    // 2: LOADI r0=5, SUB r3=r0-r0, read r3 back via ADD r1=r3+r3
    push(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'd5);
    push(OP_SUB,   2'd3, 2'd0, 2'd0, 4'd0);
    push(OP_ADD,   2'd1, 2'd3, 2'd3, 4'd0);
    wait_rsp(3);
    expect_rsp("t2_loadi", 2'd0, 4'd5);
    if (rq.size() > 0) check("t2_sub_zero", 32'(rq[0].flags[0]), 32'd1);
    expect_rsp("t2_sub", 2'd3, 4'd0);
    expect_rsp("t2_r3", 2'd1, 4'd0);
    check("t2_op_count", 32'(op_count), 32'd6);

    // 3: dependent back-to-back commands see written-back values
    push(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'd1);
    push(OP_ADD,   2'd1, 2'd0, 2'd0, 4'd0);
    push(OP_ADD,   2'd2, 2'd1, 2'd1, 4'd0);
    wait_rsp(3);
    expect_rsp("t3_loadi", 2'd0, 4'd1);
    expect_rsp("t3_add1", 2'd1, 4'd2);
    expect_rsp("t3_add2", 2'd2, 4'd4);
    check("t3_op_count", 32'(op_count), 32'd9);

    // 4: stalled response, 6 continuous pushes, only 5 fit
    ifc.rsp_ready = 1'b0;
    n_acc = 0;
    rdy6  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifc.cmd_opcode = OP_LOADI;
      ifc.cmd_rd     = 2'(i);
      ifc.cmd_imm    = 4'(i + 1);
      ifc.cmd_valid  = 1'b1;
      if (ifc.cmd_ready) n_acc++;
      if (i == 5) rdy6 = ifc.cmd_ready;
      tick();
    end
    ifc.cmd_valid = 1'b0;
    check("t4_accepted", 32'(n_acc), 32'd5);
    check("t4_ready_6th", 32'(rdy6), 32'd0);
    check("t4_stall_valid", 32'(ifc.rsp_valid), 32'd1);
    check("t4_stall_result", 32'(ifc.rsp_result), 32'd1);
    ifc.rsp_ready = 1'b1;
    wait_rsp(5);
    expect_rsp("t4_q0", 2'd0, 4'd1);
    expect_rsp("t4_q1", 2'd1, 4'd2);
    expect_rsp("t4_q2", 2'd2, 4'd3);
    expect_rsp("t4_q3", 2'd3, 4'd4);
    expect_rsp("t4_q4", 2'd0, 4'd5);
    check("t4_op_count", 32'(op_count), 32'd14);

    // 5: reset while the first of a burst is in ISSUE
    push(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'd7);
    push(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("t5_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    check("t5_op_count", 32'(op_count), 32'd0);
    tick(); tick(); tick();
    check("t5_no_rsp", 32'(rq.size()), 32'd0);
    rq.delete();
    push(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0);
    wait_rsp(1);
    if (rq.size() > 0) check("t5_add_flags", 32'(rq[0].flags), 32'b00001);
    expect_rsp("t5_add", 2'd2, 4'd0);
    check("t5_op_count_after", 32'(op_count), 32'd1);

    // 6: rsp_ready high, one response pulse every 3 cycles
    push(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'd9);
    push(OP_LOADI, 2'd2, 2'd0, 2'd0, 4'd10);
    push(OP_LOADI, 2'd3, 2'd0, 2'd0, 4'd11);
    wait_rsp(3);
    c0 = (rq.size() > 0) ? rq[0].cyc : 0;
    c1 = (rq.size() > 1) ? rq[1].cyc : 0;
    c2 = (rq.size() > 2) ? rq[2].cyc : 0;
    check("t6_gap01", 32'(c1 - c0), 32'd3);
    check("t6_gap12", 32'(c2 - c1), 32'd3);
    expect_rsp("t6_a", 2'd1, 4'd9);
    expect_rsp("t6_b", 2'd2, 4'd10);
    expect_rsp("t6_c", 2'd3, 4'd11);
    check("t6_valid_low", 32'(ifc.rsp_valid), 32'd0);
    check("t6_op_count", 32'(op_count), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
